// File: rtl/dac_mux_sequencer.sv
// Drives an analog mux and a DAC7611-class serial DAC (SCLK/SDI/LD/CLR) over NUM_CH channels per frame.
// Optional: define DAC_MUX_CONT_EN for free-running back-to-back frames after a single start.
module dac_mux_sequencer #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 12,
  parameter int CLK_DIV    = 2,
  parameter int SETTLE_CYC = 8,
  parameter int LD_CYC     = 2,
  parameter int CLR_CYC    = 3,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     clr_req,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic [CH_W-1:0]          mux_sel,
  output logic                     mux_en,
  output logic                     dac_sclk,
  output logic                     dac_sdi,
  output logic                     dac_ld_n,
  output logic                     dac_clr_n
);
  localparam int M1      = (SETTLE_CYC > LD_CYC) ? SETTLE_CYC : LD_CYC;
  localparam int M2      = (CLR_CYC > CLK_DIV) ? CLR_CYC : CLK_DIV;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, SHIFT, LOAD} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic                      ph_q, ph_d;   // 0: SCLK low phase, 1: SCLK high phase
  logic [NUM_CH*DATA_W-1:0]  data_q, data_d;
  logic                      done_d, run_d, sdi_d;
  logic [DATA_W-1:0]         cur_code;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = CNT_W'(CLR_CYC - 1);
        end else if (start) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
          ch_d    = '0;
          data_d  = ch_data;
        end
      end
      CLEAR: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = SHIFT;
          cnt_d   = CNT_W'(CLK_DIV - 1);
          bit_d   = BIT_W'(DATA_W - 1);
          ph_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!ph_q) begin
          ph_d  = 1'b1;
          cnt_d = CNT_W'(CLK_DIV - 1);
        end else if (bit_q == '0) begin
          state_d = LOAD;
          cnt_d   = CNT_W'(LD_CYC - 1);
        end else begin
          // next bit is presented only as SCLK falls, so SDI is steady across the rise
          bit_d = bit_q - BIT_W'(1);
          ph_d  = 1'b0;
          cnt_d = CNT_W'(CLK_DIV - 1);
        end
      end
      LOAD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (ch_q == CH_W'(NUM_CH - 1)) begin
          done_d = 1'b1;
`ifdef DAC_MUX_CONT_EN
          if (clr_req) begin
            state_d = CLEAR;
            cnt_d   = CNT_W'(CLR_CYC - 1);
          end else begin
            state_d = SETTLE;
            cnt_d   = CNT_W'(SETTLE_CYC - 1);
            ch_d    = '0;
            data_d  = ch_data;
          end
`else
          state_d = IDLE;
`endif
        end else begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
          ch_d    = ch_q + CH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs are registered from next-state values so they line up with the state register
  always_comb begin
    cur_code = data_d[ch_d*DATA_W +: DATA_W];
    run_d    = (state_d == SETTLE) || (state_d == SHIFT) || (state_d == LOAD);
    sdi_d    = (state_d == SHIFT) ? cur_code[bit_d] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ch_q       <= '0;
      bit_q      <= '0;
      ph_q       <= 1'b0;
      data_q     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      mux_sel    <= '0;
      mux_en     <= 1'b0;
      dac_sclk   <= 1'b1;
      dac_sdi    <= 1'b0;
      dac_ld_n   <= 1'b1;
      dac_clr_n  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      bit_q      <= bit_d;
      ph_q       <= ph_d;
      data_q     <= data_d;
      busy       <= (state_d != IDLE);
      frame_done <= done_d;
      mux_sel    <= run_d ? ch_d : '0;
      mux_en     <= run_d;
      dac_sclk   <= !((state_d == SHIFT) && !ph_d);
      dac_sdi    <= sdi_d;
      dac_ld_n   <= (state_d != LOAD);
      dac_clr_n  <= (state_d != CLEAR);
    end
  end
endmodule

// File: tb/tb_dac_mux_sequencer.sv
// Scoreboard bench for dac_mux_sequencer: expected SDI bits/channels queued at start, popped at each SCLK rise.
module tb_dac_mux_sequencer;
  localparam int NUM_CH = 4, DATA_W = 12, CLK_DIV = 2, SETTLE_CYC = 8, LD_CYC = 2, CLR_CYC = 3;
  localparam int FRAME = NUM_CH * (SETTLE_CYC + 2*CLK_DIV*DATA_W + LD_CYC);
  localparam logic [8:0] RST_VEC = 9'b0_0_00_0_1_0_1_1;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, clr_req = 1'b0;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;
  logic busy, frame_done, mux_en, dac_sclk, dac_sdi, dac_ld_n, dac_clr_n;
  logic [1:0] mux_sel;
  int checks = 0, passed = 0, cyc = 0;

  typedef struct { int ch; logic b; } exp_t;
  exp_t sb[$];

  dac_mux_sequencer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV),
    .SETTLE_CYC(SETTLE_CYC), .LD_CYC(LD_CYC), .CLR_CYC(CLR_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .clr_req(clr_req), .ch_data(ch_data),
    .busy(busy), .frame_done(frame_done), .mux_sel(mux_sel), .mux_en(mux_en),
    .dac_sclk(dac_sclk), .dac_sdi(dac_sdi), .dac_ld_n(dac_ld_n), .dac_clr_n(dac_clr_n));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic test_reset;
    logic [8:0] v;
    reset = 1'b1; start = 1'b0; clr_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    v = {busy, frame_done, mux_sel, mux_en, dac_sclk, dac_sdi, dac_ld_n, dac_clr_n};
    checks++; if (v !== RST_VEC) $display("FAIL reset_outputs got %b want %b", v, RST_VEC); else passed++;
    checks++; if (dac_sclk !== 1'b1) $display("FAIL reset_sclk got %b want 1", dac_sclk); else passed++;
    checks++; if (dac_ld_n !== 1'b1) $display("FAIL reset_ld_n got %b want 1", dac_ld_n); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clr_and_start;
    int n_clr = 0, act = 0;
    @(negedge clk); clr_req = 1'b1; start = 1'b1;
    @(negedge clk); clr_req = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL clr_busy got %b want 1", busy); else passed++;
    for (int i = 0; i < 12; i++) begin
      if (!dac_clr_n) n_clr++;
      if (!dac_sclk || !dac_ld_n || mux_en) act++;
      start = (i == 1);  // lands while CLEAR is running and must be dropped
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (n_clr != CLR_CYC) $display("FAIL clr_width got %0d want %0d", n_clr, CLR_CYC); else passed++;
    checks++; if (act != 0) $display("FAIL clr_no_shift got %0d active cycles want 0", act); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL clr_busy_fall got %b want 0", busy); else passed++;
  endtask

  task automatic test_frame(input logic [NUM_CH*DATA_W-1:0] data);
    exp_t e;
    int t_busy = 0, t_rise = 0, n_lo = 0, n_hi = 0, nrise = 0, ld_lo = 0, en_bad = 0;
    logic psclk = 1'b1, pld = 1'b1, sdi_lo = 1'b0, hi_valid = 1'b0, got_fd = 1'b0;
    sb.delete();
    for (int c = 0; c < NUM_CH; c++)
      for (int b = DATA_W-1; b >= 0; b--) begin
        e.ch = c; e.b = data[c*DATA_W + b]; sb.push_back(e);
      end
    ch_data = data;
    @(negedge clk); start = 1'b1;
    for (int i = 0; i < 2*FRAME; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0; ch_data = ~data;  // post-latch change must not reach the frame
        checks++; if (busy !== 1'b1) $display("FAIL busy_rise got %b want 1", busy); else passed++;
        t_busy = cyc;
      end
      start   = (i == 100);
      clr_req = (i == 100);
      if (mux_en !== busy) en_bad++;
      if (!dac_sclk) begin
        if (psclk) begin
          if (hi_valid) begin
            checks++; if (n_hi != CLK_DIV) $display("FAIL sclk_high got %0d want %0d", n_hi, CLK_DIV); else passed++;
          end
          n_lo = 0; sdi_lo = dac_sdi;
        end
        n_lo++;
      end else begin
        if (!psclk) begin
          checks++; if (n_lo != CLK_DIV) $display("FAIL sclk_low got %0d want %0d", n_lo, CLK_DIV); else passed++;
          checks++; if (dac_sdi !== sdi_lo) $display("FAIL sdi_stable got %b want %b", dac_sdi, sdi_lo); else passed++;
          if (sb.size() == 0) begin
            checks++; $display("FAIL sb_extra_bit got rise %0d want none", nrise);
          end else begin
            e = sb.pop_front();
            checks++; if (dac_sdi !== e.b) $display("FAIL sdi_bit got %b want %b (rise %0d)", dac_sdi, e.b, nrise); else passed++;
            checks++; if (mux_sel !== 2'(e.ch)) $display("FAIL mux_sel got %0d want %0d", mux_sel, e.ch); else passed++;
          end
          nrise++; t_rise = cyc; n_hi = 0; hi_valid = 1'b1;
        end
        n_hi++;
      end
      if (!dac_ld_n && pld) begin
        checks++; if (cyc - t_rise != CLK_DIV || nrise % DATA_W != 0)
          $display("FAIL ld_delay got %0d cyc after rise %0d want %0d after rise mult of %0d", cyc - t_rise, nrise, CLK_DIV, DATA_W);
        else passed++;
        ld_lo = 0; hi_valid = 1'b0;
      end
      if (!dac_ld_n) ld_lo++;
      if (dac_ld_n && !pld) begin
        checks++; if (ld_lo != LD_CYC) $display("FAIL ld_width got %0d want %0d", ld_lo, LD_CYC); else passed++;
      end
      psclk = dac_sclk; pld = dac_ld_n;
      if (frame_done) begin
        got_fd = 1'b1;
        checks++; if (cyc - t_busy != FRAME) $display("FAIL frame_time got %0d want %0d", cyc - t_busy, FRAME); else passed++;
        break;
      end
    end
    start = 1'b0; clr_req = 1'b0;
    checks++; if (!got_fd) $display("FAIL frame_timeout got no frame_done want one within %0d", 2*FRAME); else passed++;
    checks++; if (sb.size() != 0) $display("FAIL sb_left got %0d bits want 0", sb.size()); else passed++;
    checks++; if (en_bad != 0) $display("FAIL mux_en_track got %0d bad cycles want 0", en_bad); else passed++;
`ifdef DAC_MUX_CONT_EN
    checks++; if (busy !== 1'b1) $display("FAIL cont_busy_after got %b want 1", busy); else passed++;
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
`else
    checks++; if (busy !== 1'b0) $display("FAIL busy_after got %b want 0", busy); else passed++;
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_midframe;
    logic found = 1'b0;
    logic [8:0] v;
    ch_data = {12'h123, 12'h456, 12'h789, 12'hABC};
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 2*FRAME; i++) begin
      if (mux_sel == 2'd2 && !dac_sclk) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!found) $display("FAIL mid_reach_ch2 got no ch2 shift want one"); else passed++;
    reset = 1'b1;
    @(negedge clk);
    v = {busy, frame_done, mux_sel, mux_en, dac_sclk, dac_sdi, dac_ld_n, dac_clr_n};
    checks++; if (v !== RST_VEC) $display("FAIL mid_reset_outputs got %b want %b", v, RST_VEC); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

`ifdef DAC_MUX_CONT_EN
  task automatic test_cont;
    int t_prev = 0, nfd = 0, nbusy_lo = 0, n_clr = 0, act = 0;
    logic got = 1'b0;
    ch_data = {12'h0AB, 12'h555, 12'hFFF, 12'h800};
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 4*FRAME && nfd < 3; i++) begin
      if (!busy) nbusy_lo++;
      if (frame_done) begin
        if (nfd > 0) begin
          checks++; if (cyc - t_prev != FRAME) $display("FAIL cont_period got %0d want %0d", cyc - t_prev, FRAME); else passed++;
        end
        t_prev = cyc; nfd++;
      end
      @(negedge clk);
    end
    checks++; if (nfd != 3) $display("FAIL cont_frames got %0d want 3", nfd); else passed++;
    checks++; if (nbusy_lo != 0) $display("FAIL cont_busy_gap got %0d want 0", nbusy_lo); else passed++;
    clr_req = 1'b1;
    for (int i = 0; i < 2*FRAME; i++) begin
      @(negedge clk);
      if (frame_done) begin got = 1'b1; break; end
    end
    clr_req = 1'b0;
    checks++; if (!got) $display("FAIL cont_clr_timeout got no frame_done want one"); else passed++;
    for (int i = 0; i < 10; i++) begin
      if (!dac_clr_n) n_clr++;
      if (!dac_sclk || !dac_ld_n) act++;
      @(negedge clk);
    end
    checks++; if (n_clr != CLR_CYC) $display("FAIL cont_clr_width got %0d want %0d", n_clr, CLR_CYC); else passed++;
    checks++; if (act != 0) $display("FAIL cont_clr_activity got %0d want 0", act); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL cont_idle got busy %b want 0", busy); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_clr_and_start();
    test_frame({12'h0AB, 12'h555, 12'hFFF, 12'h800});
    test_reset_midframe();
    test_frame({12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)});
`ifdef DAC_MUX_CONT_EN
    test_cont();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
